// File: rtl/clock_divider_pkg.sv
// Shared constants, state encoding and divisor helpers for the burst clock divider.
package clock_divider_pkg;

    localparam int unsigned DIV_W       = 8;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned NUM_PERIODS = 8;

    localparam logic [DIV_W-1:0] DEFAULT_DIV = 8'd2;
    localparam logic [CNT_W-1:0] LAST_PERIOD = CNT_W'(NUM_PERIODS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Divisors below 2 cannot form a high and a low phase, so clamp them.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] de);
        return de >> 1;
    endfunction

    function automatic logic [DIV_W-1:0] low_len(input logic [DIV_W-1:0] de);
        return de - (de >> 1);
    endfunction

endpackage

// File: rtl/clock_divider.sv
// Burst clock divider: on start, emits NUM_PERIODS periods of i_clk/De, then one
// DONE cycle before returning to IDLE.
module clock_divider
    import clock_divider_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [8:0] i_config,
    input  logic       i_start_n,
    output logic       o_idle,
    output logic       o_clk
);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   half_q, half_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic               clk_q, clk_d;
    logic               idle_q, idle_d;
    logic [DIV_W-1:0]   de_c;

    // Divisor is only written in IDLE, so it stays stable for the whole burst.
    always_comb begin
        div_d = div_q;
        if ((state_q == IDLE) && i_config[0]) begin
            div_d = i_config[8:1];
        end
    end

    assign de_c = eff_div(div_d);

    // half_q holds the cycles left in the current phase after this one.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        per_d   = per_q;
        clk_d   = clk_q;
        idle_d  = idle_q;

        case (state_q)
            IDLE: begin
                clk_d  = 1'b0;
                idle_d = 1'b1;
                if (!i_start_n) begin
                    state_d = RUN;
                    idle_d  = 1'b0;
                    clk_d   = 1'b1;
                    per_d   = '0;
                    half_d  = high_len(de_c) - DIV_W'(1);
                end
            end

            RUN: begin
                if (half_q != '0) begin
                    half_d = half_q - DIV_W'(1);
                end else if (clk_q) begin
                    clk_d  = 1'b0;
                    half_d = low_len(de_c) - DIV_W'(1);
                end else if (per_q == LAST_PERIOD) begin
                    state_d = DONE;
                    clk_d   = 1'b0;
                    half_d  = '0;
                    per_d   = '0;
                end else begin
                    per_d  = per_q + CNT_W'(1);
                    clk_d  = 1'b1;
                    half_d = high_len(de_c) - DIV_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                clk_d   = 1'b0;
                idle_d  = 1'b1;
            end

            default: begin
                state_d = IDLE;
                half_d  = '0;
                per_d   = '0;
                clk_d   = 1'b0;
                idle_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            div_q   <= DEFAULT_DIV;
            half_q  <= '0;
            per_q   <= '0;
            clk_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            per_q   <= per_d;
            clk_q   <= clk_d;
            idle_q  <= idle_d;
        end
    end

    assign o_clk  = clk_q;
    assign o_idle = idle_q;

endmodule

// File: tb/tb_clock_divider.sv
// Randomized and directed bench for clock_divider against a cycle-position model.
module tb_clock_divider;

    logic       i_clk;
    logic       i_rst;
    logic [8:0] i_config;
    logic       i_start_n;
    logic       o_idle;
    logic       o_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: a burst is a cycle position 0..8*De; o_clk is high in the first De/2
    // positions of every De-long period, position 8*De is the trailing DONE cycle.
    int m_d    = 2;
    bit m_busy = 1'b0;
    int m_de   = 2;
    int m_pos  = 0;

    clock_divider dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_config  (i_config),
        .i_start_n (i_start_n),
        .o_idle    (o_idle),
        .o_clk     (o_clk)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_clk();
        if (!m_busy || m_pos >= 8 * m_de) return 0;
        return ((m_pos % m_de) < (m_de / 2)) ? 1 : 0;
    endfunction

    task automatic model_edge(input logic [8:0] cfg, input logic sn);
        if (!m_busy) begin
            if (cfg[0]) m_d = int'(cfg[8:1]);
            if (!sn) begin
                m_busy = 1'b1;
                m_de   = (m_d < 2) ? 2 : m_d;
                m_pos  = 0;
            end
        end else if (m_pos == 8 * m_de) begin
            m_busy = 1'b0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic step(input logic [8:0] cfg, input logic sn);
        i_config  = cfg;
        i_start_n = sn;
        @(posedge i_clk);
        model_edge(cfg, sn);
        #1;
        check("o_clk", int'(o_clk), exp_clk());
        check("o_idle", int'(o_idle), m_busy ? 0 : 1);
    endtask

    task automatic do_reset(input int cycles);
        i_rst = 1'b1;
        #1;
        check("rst_clk", int'(o_clk), 0);
        check("rst_idle", int'(o_idle), 1);
        m_d    = 2;
        m_busy = 1'b0;
        m_pos  = 0;
        repeat (cycles) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // Starts one burst with divisor d and measures it against 8*De+1 idle-low cycles.
    task automatic run_burst(input int d, input bit same_edge, input string tag);
        int de, low, highs, rises, budget;
        logic prev;
        de = (d < 2) ? 2 : d;
        low = 0; highs = 0; rises = 0; budget = 0; prev = 1'b0;
        if (same_edge) begin
            step({8'(d), 1'b1}, 1'b0);
        end else begin
            step({8'(d), 1'b1}, 1'b1);
            step(9'h000, 1'b0);
        end
        while (!o_idle && budget < 2100) begin
            low++;
            if (o_clk) highs++;
            if (o_clk && !prev) rises++;
            prev = o_clk;
            step({8'($urandom_range(0, 255)), 1'($urandom_range(0, 1))}, 1'b1);
            budget++;
        end
        if (budget >= 2100) check({tag, "_timeout"}, budget, 0);
        check({tag, "_low"}, low, 8 * de + 1);
        check({tag, "_highs"}, highs, 8 * (de / 2));
        check({tag, "_rises"}, rises, 8);
        step(9'h000, 1'b1);
        check({tag, "_end_clk"}, int'(o_clk), 0);
    endtask

    initial begin
        i_rst     = 1'b1;
        i_config  = 9'h000;
        i_start_n = 1'b1;

        do_reset(16);
        step(9'h000, 1'b1);
        check("post_rst_idle", int'(o_idle), 1);
        check("post_rst_clk", int'(o_clk), 0);

        // Reset default divisor of 2 with no configuration write.
        begin
            int low = 0;
            step(9'h000, 1'b0);
            while (!o_idle && low < 100) begin
                low++;
                step(9'h000, 1'b1);
            end
            check("default_low", low, 17);
        end

        run_burst(250, 1'b0, "d250");
        run_burst(100, 1'b0, "d100");
        run_burst(4, 1'b0, "d4");
        run_burst(2, 1'b0, "d2");
        run_burst(0, 1'b0, "d0");
        run_burst(1, 1'b0, "d1");
        run_burst(7, 1'b1, "same_edge");

        // Config during a D=4 burst is dropped; a fresh write in IDLE selects D=3.
        step({8'd4, 1'b1}, 1'b1);
        step(9'h000, 1'b0);
        repeat (6) step({8'd3, 1'b1}, 1'b1);
        while (m_busy) step(9'h000, 1'b1);
        check("cfg_ignored_div", m_d, 4);
        run_burst(3, 1'b0, "d3");

        // Held-low start relaunches a burst as soon as IDLE is re-entered.
        step({8'd5, 1'b1}, 1'b1);
        repeat (45) step(9'h000, 1'b0);
        check("held_start_busy", int'(o_idle), 0);
        step(9'h000, 1'b1);
        while (m_busy) step(9'h000, 1'b1);

        // Mid-burst reset aborts immediately.
        step({8'd20, 1'b1}, 1'b0);
        repeat (13) step(9'h000, 1'b1);
        do_reset(3);
        step(9'h000, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset($urandom_range(1, 4));
            end else begin
                step({8'($urandom_range(0, 12)), 1'($urandom_range(0, 3) == 0)},
                     1'($urandom_range(0, 5) != 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
